dpram_arbiter: RTL and testbench

Round-robin arbiter that shares the 64x8 dual-port RAM (dpram) between NREQ independent requesters. Each cycle it grants up to two requests, one per RAM port. It blocks same-address hazards between the two ports and routes read data back to the issuing requester with fixed latency. It sits between client blocks and dpram and is the only driver of the dpram pins.

---
 rtl/dpram_pkg.sv | 20 ++
 rtl/rr_pick.sv | 36 +++
 rtl/dpram_arbiter.sv | 151 +++++++++++++++
 tb/tb_dpram_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// Shared types for the dual-port RAM and its round-robin arbiter.
// Holds the RAM geometry, the per-port command word and the read-return tag.
package dpram_pkg;

    localparam int DPRAM_AW = 6;
    localparam int DPRAM_DW = 8;
    localparam int IDX_W    = 3;

    typedef struct packed {
        logic                wr;
        logic [DPRAM_AW-1:0] addr;
        logic [DPRAM_DW-1:0] data;
    } port_cmd_t;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: returns the first requester at or after start (mod N)
// whose request is set and which is not masked off by excl.
module rr_pick
    import dpram_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    input  logic [N-1:0]  excl,
    output logic          found,
    output logic [IW-1:0] idx
);

    localparam int unsigned NU = N;

    int unsigned   cand;
    logic [IW-1:0] cand_i;

    always_comb begin
        found  = 1'b0;
        idx    = '0;
        cand   = 0;
        cand_i = '0;
        for (int unsigned off = 0; off < NU; off++) begin
            cand   = (32'(start) + off) % NU;
            cand_i = IW'(cand);
            if (!found && req[cand_i] && !excl[cand_i]) begin
                found = 1'b1;
                idx   = cand_i;
            end
        end
    end

endmodule

// File: rtl/dpram_arbiter.sv
// Round-robin arbiter sharing one dual-port RAM between NREQ requesters:
// up to two grants per cycle, same-address hazard blocking, tagged read return.
module dpram_arbiter
    import dpram_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = DPRAM_AW,
    parameter int DW   = DPRAM_DW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rvalid,
    output logic [NREQ*DW-1:0] rdata,
    output logic               ram_en,
    output logic               ram_wr0,
    output logic               ram_wr1,
    output logic [AW-1:0]      ram_add0,
    output logic [AW-1:0]      ram_add1,
    output logic [DW-1:0]      ram_din0,
    output logic [DW-1:0]      ram_din1,
    input  logic [DW-1:0]      ram_dout0,
    input  logic [DW-1:0]      ram_dout1
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0]     ptr;
    logic              found0, found1;
    logic [IW-1:0]     s0, s1;
    logic [NREQ-1:0]   excl0, excl1;
    logic [AW-1:0]     a_addr  [NREQ];
    logic [DW-1:0]     a_wdata [NREQ];
    port_cmd_t         cmd0, cmd1;
    tag_t              tag0_s1, tag0_s2, tag1_s1, tag1_s2;
    logic [NREQ*DW-1:0] rdata_q;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
        return (x == IW'(NREQ - 1)) ? '0 : x + 1'b1;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            a_addr[i]  = addr[i*AW +: AW];
            a_wdata[i] = wdata[i*DW +: DW];
        end
    end

    assign excl0 = '0;

    rr_pick #(.N(NREQ)) u_pick0 (
        .req   (req),
        .start (ptr),
        .excl  (excl0),
        .found (found0),
        .idx   (s0)
    );

    // Port 1 skips the port-0 winner and anything that would race it on the
    // same address; two reads of one address are allowed to pair up.
    always_comb begin
        excl1 = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            excl1[i] = (s0 == IW'(i)) ||
                       ((a_addr[i] == a_addr[s0]) && (we[i] || we[s0]));
        end
    end

    rr_pick #(.N(NREQ)) u_pick1 (
        .req   (req),
        .start (ptr),
        .excl  (excl1),
        .found (found1),
        .idx   (s1)
    );

    always_comb begin
        gnt = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            gnt[i] = !rst && ((found0 && (s0 == IW'(i))) ||
                              (found1 && (s1 == IW'(i))));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= '0;
            ram_en  <= 1'b0;
            cmd0    <= '0;
            cmd1    <= '0;
            tag0_s1 <= '0;
            tag0_s2 <= '0;
            tag1_s1 <= '0;
            tag1_s2 <= '0;
            rdata_q <= '0;
        end else begin
            ram_en <= found0;
            if (found0) begin
                cmd0.wr   <= we[s0];
                cmd0.addr <= a_addr[s0];
                cmd0.data <= a_wdata[s0];
                ptr       <= found1 ? wrap_inc(s1) : wrap_inc(s0);
            end else begin
                cmd0.wr <= 1'b0;
            end
            if (found1) begin
                cmd1.wr   <= we[s1];
                cmd1.addr <= a_addr[s1];
                cmd1.data <= a_wdata[s1];
            end else begin
                cmd1.wr <= 1'b0;
            end
            tag0_s1.vld <= found0 && !we[s0];
            tag0_s1.idx <= IDX_W'(s0);
            tag1_s1.vld <= found1 && !we[s1];
            tag1_s1.idx <= IDX_W'(s1);
            tag0_s2     <= tag0_s1;
            tag1_s2     <= tag1_s1;
            rdata_q     <= rdata;
        end
    end

    assign ram_wr0  = cmd0.wr;
    assign ram_add0 = cmd0.addr;
    assign ram_din0 = cmd0.data;
    assign ram_wr1  = cmd1.wr;
    assign ram_add1 = cmd1.addr;
    assign ram_din1 = cmd1.data;

    // RAM data is live only in the return cycle, so it is muxed in directly
    // and otherwise the registered copy keeps rdata stable.
    always_comb begin
        rvalid = '0;
        rdata  = rdata_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (tag0_s2.vld && (tag0_s2.idx == IDX_W'(i))) begin
                rvalid[i]          = 1'b1;
                rdata[i*DW +: DW]  = ram_dout0;
            end
            if (tag1_s2.vld && (tag1_s2.idx == IDX_W'(i))) begin
                rvalid[i]          = 1'b1;
                rdata[i*DW +: DW]  = ram_dout1;
            end
        end
    end

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed self-checking bench for dpram_arbiter with a behavioural 64x8
// dual-port RAM attached to the arbiter's RAM pins.
module tb_dpram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, we;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [3:0]  gnt, rvalid;
    logic [31:0] rdata;
    logic        ram_en, ram_wr0, ram_wr1;
    logic [5:0]  ram_add0, ram_add1;
    logic [7:0]  ram_din0, ram_din1, ram_dout0, ram_dout1;

    logic [7:0]  mem [64];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_a;
    logic [7:0]  pre_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dpram_arbiter #(.NREQ(4), .AW(6), .DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .ram_en    (ram_en),
        .ram_wr0   (ram_wr0),
        .ram_wr1   (ram_wr1),
        .ram_add0  (ram_add0),
        .ram_add1  (ram_add1),
        .ram_din0  (ram_din0),
        .ram_din1  (ram_din1),
        .ram_dout0 (ram_dout0),
        .ram_dout1 (ram_dout1)
    );

    always @(posedge clk) begin
        if (pre_we) mem[pre_a] <= pre_d;
        if (ram_en) begin
            if (ram_wr0) mem[ram_add0] <= ram_din0;
            if (ram_wr1) mem[ram_add1] <= ram_din1;
            ram_dout0 <= mem[ram_add0];
            ram_dout1 <= mem[ram_add1];
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [5:0] a, input logic [7:0] d);
        pre_a  = a;
        pre_d  = d;
        pre_we = 1'b1;
        step();
        pre_we = 1'b0;
    endtask

    task automatic do_reset;
        rst   = 1'b1;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        req = 4'b1111;
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
        checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL rst_ram_en got=%b exp=0", ram_en); end
        checks++; if ({ram_wr0, ram_wr1, ram_add0, ram_add1, ram_din0, ram_din1} !== 30'h0) begin
            errors++; $display("FAIL rst_ram_pins got=%h exp=0", {ram_wr0, ram_wr1, ram_add0, ram_add1, ram_din0, ram_din1});
        end
        checks++; if ({rvalid, rdata} !== 36'h0) begin errors++; $display("FAIL rst_rd got=%h exp=0", {rvalid, rdata}); end
        do_reset();
    endtask

    task automatic test_single_read;
        do_reset();
        req = 4'b0100; we = 4'b0000; addr[17:12] = 6'd5;
        #1;
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
        step(); req = '0;
        checks++; if ({ram_en, ram_wr0, ram_add0} !== {1'b1, 1'b0, 6'd5}) begin
            errors++; $display("FAIL single_cmd got=%b/%b/%0d exp=1/0/5", ram_en, ram_wr0, ram_add0);
        end
        checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL single_early got=%b exp=0000", rvalid); end
        step();
        checks++; if (rvalid !== 4'b0100) begin errors++; $display("FAIL single_rvalid got=%b exp=0100", rvalid); end
        checks++; if (rdata[23:16] !== 8'hA5) begin errors++; $display("FAIL single_rdata got=%h exp=a5", rdata[23:16]); end
        step();
        checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL single_once got=%b exp=0000", rvalid); end
        checks++; if (rdata[23:16] !== 8'hA5) begin errors++; $display("FAIL single_hold got=%h exp=a5", rdata[23:16]); end
    endtask

    task automatic test_dual_grant;
        do_reset();
        req = 4'b1111; we = 4'b0000; addr = {6'd3, 6'd2, 6'd1, 6'd0};
        #1;
        checks++; if (gnt !== 4'b0011) begin errors++; $display("FAIL dual_gnt_t got=%b exp=0011", gnt); end
        step(); req = 4'b1100;
        #1;
        checks++; if (gnt !== 4'b1100) begin errors++; $display("FAIL dual_gnt_t1 got=%b exp=1100", gnt); end
        step(); req = '0;
        checks++; if (rvalid !== 4'b0011) begin errors++; $display("FAIL dual_rv_t2 got=%b exp=0011", rvalid); end
        checks++; if (rdata[15:0] !== 16'h1110) begin errors++; $display("FAIL dual_rd_t2 got=%h exp=1110", rdata[15:0]); end
        step();
        checks++; if (rvalid !== 4'b1100) begin errors++; $display("FAIL dual_rv_t3 got=%b exp=1100", rvalid); end
        checks++; if (rdata !== 32'h13121110) begin errors++; $display("FAIL dual_rd_t3 got=%h exp=13121110", rdata); end
        step();
        checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL dual_rv_t4 got=%b exp=0000", rvalid); end
    endtask

    task automatic test_write_conflict;
        do_reset();
        req = 4'b0011; we = 4'b0001; addr[5:0] = 6'd9; addr[11:6] = 6'd9; wdata[7:0] = 8'h3C;
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wc_gnt_t got=%b exp=0001", gnt); end
        step(); req = 4'b0010;
        #1;
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL wc_gnt_t1 got=%b exp=0010", gnt); end
        checks++; if ({ram_wr0, ram_add0, ram_din0, ram_wr1} !== {1'b1, 6'd9, 8'h3C, 1'b0}) begin
            errors++; $display("FAIL wc_wcmd got=%b/%0d/%h/%b exp=1/9/3c/0", ram_wr0, ram_add0, ram_din0, ram_wr1);
        end
        step(); req = '0;
        checks++; if ({ram_wr0, ram_add0, rvalid} !== {1'b0, 6'd9, 4'b0000}) begin
            errors++; $display("FAIL wc_rcmd got=%b/%0d/%b exp=0/9/0000", ram_wr0, ram_add0, rvalid);
        end
        step();
        checks++; if (rvalid !== 4'b0010) begin errors++; $display("FAIL wc_rvalid got=%b exp=0010", rvalid); end
        checks++; if (rdata[15:8] !== 8'h3C) begin errors++; $display("FAIL wc_rdata got=%h exp=3c", rdata[15:8]); end
    endtask

    task automatic test_read_read;
        do_reset();
        req = 4'b1010; we = 4'b0000; addr[11:6] = 6'd7; addr[23:18] = 6'd7;
        #1;
        checks++; if (gnt !== 4'b1010) begin errors++; $display("FAIL rr_gnt got=%b exp=1010", gnt); end
        step(); req = '0;
        step();
        checks++; if (rvalid !== 4'b1010) begin errors++; $display("FAIL rr_rvalid got=%b exp=1010", rvalid); end
        checks++; if ({rdata[31:24], rdata[15:8]} !== 16'h7777) begin
            errors++; $display("FAIL rr_rdata got=%h exp=7777", {rdata[31:24], rdata[15:8]});
        end
    endtask

    task automatic test_fairness;
        int cnt [4];
        logic [3:0] exp_g;
        do_reset();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        req = 4'b1111; we = 4'b1111;
        addr  = {6'h23, 6'h22, 6'h21, 6'h20};
        wdata = 32'hC3C2C1C0;
        for (int c = 0; c < 8; c++) begin
            #1;
            exp_g = (c % 2 == 0) ? 4'b0011 : 4'b1100;
            checks++; if (gnt !== exp_g) begin errors++; $display("FAIL fair_gnt c=%0d got=%b exp=%b", c, gnt, exp_g); end
            checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL fair_rvalid c=%0d got=%b exp=0000", c, rvalid); end
            for (int i = 0; i < 4; i++) if (gnt[i] === 1'b1) cnt[i]++;
            step();
        end
        req = '0;
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            checks++; if (cnt[i] != 4) begin errors++; $display("FAIL fair_count r=%0d got=%0d exp=4", i, cnt[i]); end
            checks++; if (mem[6'h20 + 6'(i)] !== 8'hC0 + 8'(i)) begin
                errors++; $display("FAIL fair_mem r=%0d got=%h exp=%h", i, mem[6'h20 + 6'(i)], 8'hC0 + 8'(i));
            end
        end
    endtask

    task automatic test_reset_midflight;
        do_reset();
        req = 4'b0100; we = 4'b0000; addr[17:12] = 6'd5;
        #1;
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL mid_gnt got=%b exp=0100", gnt); end
        step(); req = '0;
        rst = 1'b1;
        #1;
        checks++; if ({ram_en, ram_wr0, ram_add0, ram_din0} !== 16'h0) begin
            errors++; $display("FAIL mid_ram got=%b/%b/%0d/%h exp=0", ram_en, ram_wr0, ram_add0, ram_din0);
        end
        checks++; if ({gnt, rvalid, rdata} !== 40'h0) begin
            errors++; $display("FAIL mid_outs got=%b/%b/%h exp=0", gnt, rvalid, rdata);
        end
        #1 rst = 1'b0;
        step();
        checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL mid_dropped got=%b exp=0000", rvalid); end
        step();
        req = 4'b0001; we = 4'b0001; addr[5:0] = 6'd11; wdata[7:0] = 8'h55;
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_wgnt got=%b exp=0001", gnt); end
        step(); req = '0; we = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        step();
        step();
        checks++; if (mem[11] !== 8'h0B) begin errors++; $display("FAIL mid_wdropped got=%h exp=0b", mem[11]); end
        req = 4'b1111; addr = {6'd3, 6'd2, 6'd1, 6'd0};
        #1;
        checks++; if (gnt !== 4'b0011) begin errors++; $display("FAIL mid_ptr got=%b exp=0011", gnt); end
        step(); req = '0;
        step();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst   = 1'b1;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        preload(6'd0, 8'h10);
        preload(6'd1, 8'h11);
        preload(6'd2, 8'h12);
        preload(6'd3, 8'h13);
        preload(6'd5, 8'hA5);
        preload(6'd7, 8'h77);
        preload(6'd9, 8'h00);
        preload(6'd11, 8'h0B);
        test_reset();
        test_single_read();
        test_dual_grant();
        test_write_conflict();
        test_read_read();
        test_fairness();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
